// File: rtl/ibex_mem_pkg.sv
// ibex_mem_pkg: shared types and default window constants for the ibex RAM arbiter
package ibex_mem_pkg;
  typedef enum logic [1:0] {OWNER_NONE, OWNER_INSTR, OWNER_DATA} owner_e;
  localparam logic [31:0] PROT_BASE_DEF = 32'h0000_8000;
  localparam logic [31:0] PROT_LIMIT_DEF = 32'h0000_9000;
  typedef struct packed {
    logic rvalid;
    logic [31:0] rdata;
    logic err;
  } rsp_t;
endpackage

// File: rtl/ibex_mem_prot_chk.sv
// ibex_mem_prot_chk: classifies the granted access and counts blocked writes
module ibex_mem_prot_chk import ibex_mem_pkg::*; #(
  parameter int unsigned Depth = 16384,
  parameter logic [31:0] ProtBase = PROT_BASE_DEF,
  parameter logic [31:0] ProtLimit = PROT_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        we,
  input  logic [31:0] addr,
  output logic        legal,
  output logic        blocked_write,
  output logic [15:0] viol_count
);
  localparam logic [32:0] MemBytes = 33'(Depth) << 2;
  // An access is legal when it lands inside the RAM and is not a write into the window.
  always_comb begin
    legal = ({1'b0, addr} < MemBytes) && !(we && addr >= ProtBase && addr < ProtLimit);
    blocked_write = valid && we && !legal;
  end
  // Saturating count of dropped writes.
  always_ff @(posedge clk)
    if (rst) viol_count <= '0;
    else if (blocked_write && viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
endmodule

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one single-port RAM between ibex instr and data ports with a write-protected window
module ibex_mem_arbiter import ibex_mem_pkg::*; #(
  parameter int unsigned Depth = 16384,
  parameter int unsigned AddrWidth = $clog2(Depth),
  parameter int unsigned StarveLimit = 4,
  parameter logic [31:0] ProtBase = PROT_BASE_DEF,
  parameter logic [31:0] ProtLimit = PROT_LIMIT_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [31:0]          mem_rdata_i,
  output logic [15:0]          viol_count_o
);
  localparam int unsigned SW = $clog2(StarveLimit + 1);
  owner_e owner_q;
  logic err_pend_q;
  logic [SW-1:0] starve_q;
  logic instr_win, data_win, valid, legal, blocked_write;
  logic [31:0] sel_addr;
  rsp_t rsp;
  // Data wins ties unless instr has already lost StarveLimit cycles in a row.
  always_comb begin
    instr_win = !rst_i && instr_req_i && (!data_req_i || starve_q == SW'(StarveLimit));
    data_win = !rst_i && data_req_i && !instr_win;
    valid = instr_win || data_win;
    sel_addr = data_win ? data_addr_i : instr_addr_i;
  end
  ibex_mem_prot_chk #(
    .Depth(Depth),
    .ProtBase(ProtBase),
    .ProtLimit(ProtLimit)
  ) u_prot_chk (
    .clk(clk_i),
    .rst(rst_i),
    .valid(valid),
    .we(data_win && data_we_i),
    .addr(sel_addr),
    .legal(legal),
    .blocked_write(blocked_write),
    .viol_count(viol_count_o)
  );
  // Only legal accesses reach the RAM; instr fetches are always full-word reads.
  always_comb begin
    mem_req_o = valid && legal;
    mem_we_o = data_win && data_we_i && !blocked_write;
    mem_be_o = data_win ? data_be_i : 4'hF;
    mem_addr_o = sel_addr[AddrWidth+1:2];
    mem_wdata_o = data_wdata_i;
    instr_gnt_o = instr_win;
    data_gnt_o = data_win;
  end
  // Track who owns the in-flight response, whether it must be an error, and instr starvation.
  always_ff @(posedge clk_i)
    if (rst_i) begin
      owner_q <= OWNER_NONE;
      err_pend_q <= 1'b0;
      starve_q <= '0;
    end else begin
      owner_q <= instr_win ? OWNER_INSTR : data_win ? OWNER_DATA : OWNER_NONE;
      err_pend_q <= valid && !legal;
      starve_q <= (!instr_req_i || instr_win) ? '0 :
                  (starve_q == SW'(StarveLimit)) ? starve_q : starve_q + 1'b1;
    end
  // Route the response to its owner; an orphan RAM response is ignored.
  always_comb begin
    rsp.rvalid = !rst_i && owner_q != OWNER_NONE && (err_pend_q || mem_rvalid_i);
    rsp.err = err_pend_q;
    rsp.rdata = err_pend_q ? 32'h0 : mem_rdata_i;
    instr_rvalid_o = rsp.rvalid && owner_q == OWNER_INSTR;
    data_rvalid_o = rsp.rvalid && owner_q == OWNER_DATA;
    instr_err_o = instr_rvalid_o && rsp.err;
    data_err_o = data_rvalid_o && rsp.err;
    instr_rdata_o = rsp.rdata;
    data_rdata_o = rsp.rdata;
  end
endmodule
